// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel path, used by the packer and the upstream unit.
//   PIX_W      - width of an output pixel sample
//   RES_W      - width of a result sample from the processing unit
//   pix_word_t - {pix, eol, eof} word presented to the file writer
//   sat8()     - clamp an unsigned result sample to an 8-bit pixel
package pixel_pkg;

    localparam int PIX_W = 8;
    localparam int RES_W = 16;

    typedef struct packed {
        logic [PIX_W-1:0] pix;
        logic             eol;
        logic             eof;
    } pix_word_t;

    // Any result above the 8-bit range clamps to full scale.
    function automatic logic [PIX_W-1:0] sat8(input logic [RES_W-1:0] res);
        logic [PIX_W-1:0] pix_v;
        if (res > 16'd255) begin
            pix_v = 8'hFF;
        end else begin
            pix_v = res[PIX_W-1:0];
        end
        return pix_v;
    endfunction

endpackage

// File: rtl/pixel_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst (async, active high), clr (synchronous flush)
//   wr_en/wr_data - push; the caller never pushes when full
//   rd_en         - pop of the word on rd_data; ignored when empty
//   rd_data       - head word, valid while rd_valid
//   count         - number of stored words, 0..DEPTH
// Pointers carry one extra bit so full (count == DEPTH) differs from empty.
module pixel_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_rd_s;

    assign count    = wr_ptr_r - rd_ptr_r;
    assign rd_valid = (count != (AW+1)'(0));
    assign rd_data  = mem_r[rd_ptr_r[AW-1:0]];
    assign do_rd_s  = rd_en && rd_valid;

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers, flushed by reset or clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= (AW+1)'(0);
            rd_ptr_r <= (AW+1)'(0);
        end else if (clr) begin
            wr_ptr_r <= (AW+1)'(0);
            rd_ptr_r <= (AW+1)'(0);
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_result_packer.sv
// Saturates the 16-bit result stream to 8-bit pixels, buffers them and emits
// them with end-of-line / end-of-frame tags.
// Ports:
//   Clk, Rst (async, active high), Clr (synchronous flush)
//   In_C/In_Valid/In_Ready          - result sample input handshake
//   Out_Pix/Out_Valid/Out_Ready     - pixel output handshake
//   Out_Eol/Out_Eof                 - line / frame tags, qualified by Out_Valid
//   Sat_Count                       - saturated-sample count
// Build option PACKER_SATCNT_EN enables the Sat_Count counter; without it the
// port reads 0.
// Tags come from position counters that advance on pop, so they always
// describe the word currently at the FIFO head.
module pixel_result_packer
    import pixel_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int CHANNELS = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Clr,
    input  logic [RES_W-1:0]  In_C,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [PIX_W-1:0]  Out_Pix,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Out_Eol,
    output logic              Out_Eof,
    output logic [15:0]       Sat_Count
);

    localparam int AW       = $clog2(DEPTH);
    localparam int LINE_LEN = IMG_W * CHANNELS;
    localparam int COL_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic             stage_valid_r;
    logic [PIX_W-1:0] stage_pix_r;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    logic [AW:0]      fifo_count_s;
    logic [AW:0]      occupancy_s;
    logic [PIX_W-1:0] fifo_pix_s;
    logic             fifo_valid_s;
    logic             in_ready_s;
    logic             take_s;
    logic             pop_s;
    logic             eol_s;
    logic             eof_s;
    pix_word_t        out_word_s;

    // The stage register counts toward capacity so an accepted sample always
    // has a FIFO slot waiting for it; Rst holds the input closed.
    assign occupancy_s = fifo_count_s + {{AW{1'b0}}, stage_valid_r};
    assign in_ready_s  = !Rst && !Clr && (occupancy_s < (AW+1)'(DEPTH));
    assign take_s      = In_Valid && in_ready_s;
    assign pop_s       = fifo_valid_s && Out_Ready && !Clr;

    assign eol_s = (col_r == COL_W'(LINE_LEN - 1));
    assign eof_s = eol_s && (row_r == ROW_W'(IMG_H - 1));

    pixel_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (Clk),
        .rst      (Rst),
        .clr      (Clr),
        .wr_en    (stage_valid_r && !Clr),
        .wr_data  (stage_pix_r),
        .rd_en    (pop_s),
        .rd_data  (fifo_pix_s),
        .rd_valid (fifo_valid_s),
        .count    (fifo_count_s)
    );

    // Saturating input stage; drains into the FIFO on the following edge.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stage_valid_r <= 1'b0;
            stage_pix_r   <= {PIX_W{1'b0}};
        end else if (Clr) begin
            stage_valid_r <= 1'b0;
            stage_pix_r   <= {PIX_W{1'b0}};
        end else begin
            stage_valid_r <= take_s;
            if (take_s) begin
                stage_pix_r <= sat8(In_C);
            end
        end
    end

    // Column/row position of the head word; wraps to 0 after the frame end.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (Clr) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (pop_s) begin
            if (eol_s) begin
                col_r <= {COL_W{1'b0}};
                if (eof_s) begin
                    row_r <= {ROW_W{1'b0}};
                end else begin
                    row_r <= row_r + ROW_W'(1);
                end
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Output word; pixel and tags read as 0 while nothing is valid.
    always_comb begin
        out_word_s = '0;
        if (fifo_valid_s) begin
            out_word_s.pix = fifo_pix_s;
            out_word_s.eol = eol_s;
            out_word_s.eof = eof_s;
        end else begin
            out_word_s = '0;
        end
    end

    assign In_Ready  = in_ready_s;
    assign Out_Valid = fifo_valid_s;
    assign Out_Pix   = out_word_s.pix;
    assign Out_Eol   = out_word_s.eol;
    assign Out_Eof   = out_word_s.eof;

`ifdef PACKER_SATCNT_EN
    logic [15:0] sat_count_r;

    // Counts accepted samples that clamp, holding at full scale.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sat_count_r <= 16'd0;
        end else if (Clr) begin
            sat_count_r <= 16'd0;
        end else if (take_s && (In_C > 16'd255) && (sat_count_r != 16'hFFFF)) begin
            sat_count_r <= sat_count_r + 16'd1;
        end
    end

    assign Sat_Count = sat_count_r;
`else
    assign Sat_Count = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_result_packer.sv
// Directed bench for pixel_result_packer, built with a small image
// (4 x 3 pixels, 3 channels -> 12 samples per line, 36 per frame).
module tb_pixel_result_packer;

    localparam int DEPTH    = 16;
    localparam int IMG_W    = 4;
    localparam int IMG_H    = 3;
    localparam int CHANNELS = 3;
    localparam int LINE     = IMG_W * CHANNELS;
    localparam int FRAME    = LINE * IMG_H;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Clr;
    logic [15:0] In_C;
    logic        In_Valid;
    logic        In_Ready;
    logic [7:0]  Out_Pix;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Out_Eol;
    logic        Out_Eof;
    logic [15:0] Sat_Count;

    int          vectors    = 0;
    int          miscompares = 0;
    int          pop_idx    = 0;
    logic [7:0]  exp_q [$];

    logic [15:0] basic_in  [4] = '{16'h0002, 16'h00FF, 16'h0100, 16'hFFFF};
    logic [7:0]  basic_out [4] = '{8'h02, 8'hFF, 8'hFF, 8'hFF};

    always #5 Clk = ~Clk;

    pixel_result_packer #(
        .DEPTH    (DEPTH),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .CHANNELS (CHANNELS)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Clr       (Clr),
        .In_C      (In_C),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Out_Pix   (Out_Pix),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Eol   (Out_Eol),
        .Out_Eof   (Out_Eof),
        .Sat_Count (Sat_Count)
    );

    function automatic logic [7:0] ref_sat(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

    function automatic logic ref_eol(input int idx);
        return ((idx % LINE) == LINE - 1);
    endfunction

    function automatic logic ref_eof(input int idx);
        return ref_eol(idx) && (((idx / LINE) % IMG_H) == IMG_H - 1);
    endfunction

    task automatic step;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Rst = 1'b1; Clr = 1'b0; In_C = 16'h0; In_Valid = 1'b0; Out_Ready = 1'b0;
        step; step; #2;
        vectors++; if (In_Ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", In_Ready); end
        vectors++; if (Out_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", Out_Valid); end
        vectors++; if (Out_Pix !== 8'h00) begin miscompares++; $display("FAIL reset_out_pix: got %h want 00", Out_Pix); end
        vectors++; if ({Out_Eol, Out_Eof} !== 2'b00) begin miscompares++; $display("FAIL reset_tags: got %b%b want 00", Out_Eol, Out_Eof); end
        vectors++; if (Sat_Count !== 16'h0) begin miscompares++; $display("FAIL reset_sat_count: got %h want 0000", Sat_Count); end
        Rst = 1'b0; #1;
        vectors++; if (In_Ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", In_Ready); end
        step;
        pop_idx = 0;
        exp_q.delete();
    endtask

    // Four samples back to back; first output visible two edges after input.
    task automatic test_basic;
        logic exp_valid;
        Out_Ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                In_Valid = 1'b1; In_C = basic_in[c];
            end else begin
                In_Valid = 1'b0; In_C = 16'h0;
            end
            #2;
            exp_valid = (c >= 2) && (c < 6);
            vectors++;
            if (Out_Valid !== exp_valid || In_Ready !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_valid c=%0d: got valid=%b ready=%b want valid=%b ready=1", c, Out_Valid, In_Ready, exp_valid);
            end
            if (exp_valid) begin
                vectors++;
                if (Out_Pix !== basic_out[c-2] || Out_Eol !== ref_eol(pop_idx) || Out_Eof !== ref_eof(pop_idx)) begin
                    miscompares++;
                    $display("FAIL basic_pix c=%0d: got %h eol=%b eof=%b want %h eol=%b eof=%b", c, Out_Pix, Out_Eol, Out_Eof,
                             basic_out[c-2], ref_eol(pop_idx), ref_eof(pop_idx));
                end
                pop_idx++;
            end
            step;
        end
        vectors++;
`ifdef PACKER_SATCNT_EN
        if (Sat_Count !== 16'd2) begin miscompares++; $display("FAIL basic_sat_count: got %0d want 2", Sat_Count); end
`else
        if (Sat_Count !== 16'd0) begin miscompares++; $display("FAIL basic_sat_count: got %0d want 0", Sat_Count); end
`endif
    endtask

    // Consumer stalled: exactly DEPTH samples accepted, head word held stable.
    task automatic test_fill;
        int acc = 0;
        Out_Ready = 1'b0;
        In_Valid  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            In_C = 16'(c * 7 + 3);
            #2;
            if (!In_Ready) break;
            exp_q.push_back(ref_sat(In_C));
            acc++;
            if (Out_Valid) begin
                vectors++;
                if (Out_Pix !== exp_q[0]) begin miscompares++; $display("FAIL fill_hold: got %h want %h", Out_Pix, exp_q[0]); end
            end
            step;
        end
        In_Valid = 1'b0;
        vectors++; if (acc !== DEPTH) begin miscompares++; $display("FAIL fill_accepts: got %0d want %0d", acc, DEPTH); end
        step; #2;
        vectors++;
        if (In_Ready !== 1'b0 || Out_Valid !== 1'b1) begin
            miscompares++; $display("FAIL fill_full_state: got ready=%b valid=%b want ready=0 valid=1", In_Ready, Out_Valid);
        end
        step;
    endtask

    // Pops everything still expected, checking order and tags.
    task automatic test_drain;
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        for (int c = 0; c < 64; c++) begin
            #2;
            if (!Out_Valid && exp_q.size() == 0) break;
            if (Out_Valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL drain_extra: got %h want no output", Out_Pix);
                end else if (Out_Pix !== exp_q[0] || Out_Eol !== ref_eol(pop_idx) || Out_Eof !== ref_eof(pop_idx)) begin
                    miscompares++;
                    $display("FAIL drain_pop %0d: got %h eol=%b eof=%b want %h eol=%b eof=%b", pop_idx, Out_Pix, Out_Eol, Out_Eof,
                             exp_q[0], ref_eol(pop_idx), ref_eof(pop_idx));
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                pop_idx++;
            end
            step;
        end
        step;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL drain_left: got %0d outstanding want 0", exp_q.size()); end
    endtask

    // Full FIFO with both sides open: one pop every cycle for 50 cycles.
    task automatic test_throughput;
        int acc = 0;
        Out_Ready = 1'b0;
        In_Valid  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            In_C = 16'(c + 16'h0040);
            #2;
            if (!In_Ready) break;
            exp_q.push_back(ref_sat(In_C));
            step;
        end
        step;
        Out_Ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            In_C = 16'(c * 131);
            #2;
            vectors++;
            if (Out_Valid !== 1'b1 || exp_q.size() == 0 || Out_Pix !== exp_q[0] ||
                Out_Eol !== ref_eol(pop_idx) || Out_Eof !== ref_eof(pop_idx)) begin
                miscompares++;
                $display("FAIL thru_pop c=%0d: got valid=%b %h eol=%b eof=%b want valid=1 %h eol=%b eof=%b", c, Out_Valid, Out_Pix,
                         Out_Eol, Out_Eof, (exp_q.size() != 0) ? exp_q[0] : 8'h00, ref_eol(pop_idx), ref_eof(pop_idx));
            end
            if (Out_Valid && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                pop_idx++;
            end
            if (In_Ready) begin
                exp_q.push_back(ref_sat(In_C));
                acc++;
            end
            step;
        end
        vectors++; if (acc < 49) begin miscompares++; $display("FAIL thru_accepts: got %0d want >= 49", acc); end
    endtask

    // Flush with 5 entries buffered via Clr, then via Rst.
    task automatic test_clear;
        for (int pass = 0; pass < 2; pass++) begin
            Out_Ready = 1'b0;
            In_Valid  = 1'b1;
            for (int c = 0; c < 5; c++) begin
                In_C = 16'(16'h0200 + c);
                step;
            end
            In_Valid = 1'b0;
            step; step; #2;
            vectors++; if (Out_Valid !== 1'b1) begin miscompares++; $display("FAIL clear_pre_valid p=%0d: got %b want 1", pass, Out_Valid); end
            if (pass == 0) begin
                Clr = 1'b1; In_Valid = 1'b1; Out_Ready = 1'b1; #1;
                vectors++; if (In_Ready !== 1'b0) begin miscompares++; $display("FAIL clear_in_ready: got %b want 0", In_Ready); end
                step;
                Clr = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
            end else begin
                Rst = 1'b1; #1;
                vectors++; if (Out_Valid !== 1'b0 || In_Ready !== 1'b0) begin
                    miscompares++; $display("FAIL rst_mid_state: got valid=%b ready=%b want 0 0", Out_Valid, In_Ready);
                end
                step;
                Rst = 1'b0;
            end
            #2;
            vectors++;
            if (Out_Valid !== 1'b0 || Out_Pix !== 8'h00 || In_Ready !== 1'b1 || Sat_Count !== 16'h0) begin
                miscompares++;
                $display("FAIL flush_state p=%0d: got valid=%b pix=%h ready=%b sat=%h want 0 00 1 0000", pass, Out_Valid, Out_Pix,
                         In_Ready, Sat_Count);
            end
            step;
            exp_q.delete();
            pop_idx = 0;
        end
    endtask

    // Two full frames plus one line: tag positions from a cleared start.
    task automatic test_frame;
        int sent = 0;
        int n_eol = 0;
        int n_eof = 0;
        int total = 2 * FRAME + LINE;
        Out_Ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            In_Valid = (sent < total);
            In_C     = 16'(sent * 3);
            #2;
            if (In_Valid && In_Ready) begin
                exp_q.push_back(ref_sat(In_C));
                sent++;
            end
            if (Out_Valid) begin
                vectors++;
                if (exp_q.size() == 0 || Out_Pix !== exp_q[0] || Out_Eol !== ref_eol(pop_idx) || Out_Eof !== ref_eof(pop_idx)) begin
                    miscompares++;
                    $display("FAIL frame_pop %0d: got %h eol=%b eof=%b want %h eol=%b eof=%b", pop_idx, Out_Pix, Out_Eol, Out_Eof,
                             (exp_q.size() != 0) ? exp_q[0] : 8'h00, ref_eol(pop_idx), ref_eof(pop_idx));
                end
                if (Out_Eol) n_eol++;
                if (Out_Eof) n_eof++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                pop_idx++;
            end
            step;
            if (sent == total && exp_q.size() == 0 && !In_Valid) break;
        end
        In_Valid = 1'b0;
        vectors++;
        if (pop_idx !== total || n_eol !== 7 || n_eof !== 2) begin
            miscompares++;
            $display("FAIL frame_totals: got pops=%0d eol=%0d eof=%0d want pops=%0d eol=7 eof=2", pop_idx, n_eol, n_eof, total);
        end
    endtask

    // Random stalls on both sides; stalled outputs must not change.
    task automatic test_random;
        logic       hold = 1'b0;
        logic [7:0] h_pix = 8'h00;
        logic       h_eol = 1'b0;
        logic       h_eof = 1'b0;
        for (int c = 0; c < 400; c++) begin
            In_Valid  = ($urandom_range(0, 2) != 0);
            In_C      = ($urandom_range(0, 1) != 0) ? 16'($urandom()) : 16'($urandom_range(0, 255));
            Out_Ready = ($urandom_range(0, 2) == 0);
            #2;
            if (hold) begin
                vectors++;
                if (Out_Valid !== 1'b1 || Out_Pix !== h_pix || Out_Eol !== h_eol || Out_Eof !== h_eof) begin
                    miscompares++;
                    $display("FAIL rand_hold c=%0d: got valid=%b %h %b%b want valid=1 %h %b%b", c, Out_Valid, Out_Pix, Out_Eol, Out_Eof,
                             h_pix, h_eol, h_eof);
                end
            end
            if (In_Valid && In_Ready) exp_q.push_back(ref_sat(In_C));
            if (Out_Valid && Out_Ready) begin
                vectors++;
                if (exp_q.size() == 0 || Out_Pix !== exp_q[0] || Out_Eol !== ref_eol(pop_idx) || Out_Eof !== ref_eof(pop_idx)) begin
                    miscompares++;
                    $display("FAIL rand_pop %0d: got %h eol=%b eof=%b want %h eol=%b eof=%b", pop_idx, Out_Pix, Out_Eol, Out_Eof,
                             (exp_q.size() != 0) ? exp_q[0] : 8'h00, ref_eol(pop_idx), ref_eof(pop_idx));
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                pop_idx++;
            end
            hold  = Out_Valid && !Out_Ready;
            h_pix = Out_Pix;
            h_eol = Out_Eol;
            h_eof = Out_Eof;
            step;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_fill;
        test_drain;
        test_throughput;
        In_Valid = 1'b0;
        test_drain;
        test_clear;
        test_frame;
        test_random;
        test_drain;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
